// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: holds a CPU in reset for a fixed number of cycles, lets it
// run, and stops it on halt, watchdog expiry or a stalled program counter.
// Optional PC history buffer is built when RUN_CTRL_TRACE_EN is defined.
module cpu_run_ctrl #(
    parameter int unsigned PC_W        = 8,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned RST_CYCLES  = 3,
    parameter int unsigned MAX_CYCLES  = 1000,
    parameter int unsigned STALL_LIMIT = 16,
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cpu_hlt,
    input  logic [PC_W-1:0]  cpu_pc,
    output logic             cpu_rst_n,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic             stall,
    output logic [PC_W-1:0]  halt_pc,
    output logic [CNT_W-1:0] cycle_count
`ifdef RUN_CTRL_TRACE_EN
    ,
    input  logic [$clog2(TRACE_DEPTH)-1:0] trace_idx,
    output logic [PC_W-1:0]                trace_pc
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [7:0]       RST_LAST   = 8'(RST_CYCLES - 1);
    localparam logic [7:0]       STALL_LAST = 8'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0] WDOG_LAST  = CNT_W'(MAX_CYCLES - 1);

    // Reject parameter values outside their legal ranges at elaboration
    if (RST_CYCLES < 1 || RST_CYCLES > 255) begin : g_bad_rst_cycles
        $error("cpu_run_ctrl: RST_CYCLES must be 1..255");
    end
    if (MAX_CYCLES < 1 || MAX_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_max_cycles
        $error("cpu_run_ctrl: MAX_CYCLES must be 1..2^CNT_W-1");
    end
    if (STALL_LIMIT < 2 || STALL_LIMIT > 255) begin : g_bad_stall_limit
        $error("cpu_run_ctrl: STALL_LIMIT must be 2..255");
    end
    if (TRACE_DEPTH < 2 || (TRACE_DEPTH & (TRACE_DEPTH - 1)) != 0) begin : g_bad_trace_depth
        $error("cpu_run_ctrl: TRACE_DEPTH must be a power of 2, at least 2");
    end

    state_t          state;
    state_t          state_nxt;
    logic [7:0]      rst_cnt;
    logic [7:0]      stall_cnt;
    logic [7:0]      stall_cnt_nxt;
    logic [PC_W-1:0] prev_pc;
    logic            pc_same;
    logic            term_halt;
    logic            term_wdog;
    logic            term_stall;
    logic            run_end;
    logic            enter_reset;

    // Next-state and termination decode; halt beats watchdog beats stall
    always_comb begin
        state_nxt  = state;
        term_halt  = 1'b0;
        term_wdog  = 1'b0;
        term_stall = 1'b0;
        // cycle_count is 0 only in the first RUN cycle, where prev_pc is stale
        pc_same       = (cycle_count != '0) && (cpu_pc == prev_pc);
        stall_cnt_nxt = pc_same ? stall_cnt + 8'd1 : '0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RESET;
            end
            S_RESET: begin
                if (rst_cnt == RST_LAST) state_nxt = S_RUN;
            end
            S_RUN: begin
                term_halt  = cpu_hlt;
                term_wdog  = !cpu_hlt && (cycle_count == WDOG_LAST);
                term_stall = !cpu_hlt && !term_wdog && pc_same &&
                             (stall_cnt_nxt == STALL_LAST);
                if (term_halt || term_wdog || term_stall) state_nxt = S_DONE;
            end
            S_DONE: begin
                if (start) state_nxt = S_RESET;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign run_end     = term_halt || term_wdog || term_stall;
    assign enter_reset = (state != S_RESET) && (state_nxt == S_RESET);

    // State register with status outputs registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cpu_rst_n <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cpu_rst_n <= (state_nxt == S_RUN) || (state_nxt == S_DONE);
            busy      <= (state_nxt == S_RESET) || (state_nxt == S_RUN);
            done      <= (state_nxt == S_DONE);
        end
    end

    // Reset timer, run counters and termination capture
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_cnt     <= '0;
            stall_cnt   <= '0;
            prev_pc     <= '0;
            timeout     <= 1'b0;
            stall       <= 1'b0;
            halt_pc     <= '0;
            cycle_count <= '0;
        end else if (enter_reset) begin
            rst_cnt     <= '0;
            stall_cnt   <= '0;
            prev_pc     <= '0;
            timeout     <= 1'b0;
            stall       <= 1'b0;
            halt_pc     <= '0;
            cycle_count <= '0;
        end else if (state == S_RESET) begin
            rst_cnt <= rst_cnt + 8'd1;
        end else if (state == S_RUN) begin
            prev_pc   <= cpu_pc;
            stall_cnt <= stall_cnt_nxt;
            if (run_end) begin
                halt_pc <= cpu_pc;
                timeout <= term_wdog;
                stall   <= term_stall;
            end else begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

`ifdef RUN_CTRL_TRACE_EN
    localparam int unsigned IDX_W = $clog2(TRACE_DEPTH);

    logic [PC_W-1:0]  trace_mem [TRACE_DEPTH];
    logic [IDX_W-1:0] trace_wptr;
    logic [IDX_W-1:0] trace_rptr;

    // Circular PC history, cleared so unwritten slots read as zero
    always_ff @(posedge clk) begin
        if (rst || enter_reset) begin
            trace_wptr <= '0;
            for (int unsigned i = 0; i < TRACE_DEPTH; i++) begin
                trace_mem[i] <= '0;
            end
        end else if (state == S_RUN) begin
            trace_mem[trace_wptr] <= cpu_pc;
            trace_wptr            <= trace_wptr + IDX_W'(1);
        end
    end

    assign trace_rptr = trace_wptr - IDX_W'(1) - trace_idx;
    assign trace_pc   = trace_mem[trace_rptr];
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed run table, reset corner sequences and random
// runs checked against a run-level model of cpu_run_ctrl.
module tb_cpu_run_ctrl;

    localparam int PC_W        = 8;
    localparam int CNT_W       = 16;
    localparam int RST_CYCLES  = 3;
    localparam int MAX_CYCLES  = 20;
    localparam int STALL_LIMIT = 4;
    localparam int TRACE_DEPTH = 8;
    localparam int NONE        = 255;

    typedef int unsigned pcq_t[$];

    typedef struct {
        string name;
        int    stuck_from;
        int    stuck_pc;
        int    halt_at;
        bit    start_in_run;
        int    exp_cc;
        bit    exp_to;
        bit    exp_st;
        int    exp_hpc;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             start;
    logic             cpu_hlt;
    logic [PC_W-1:0]  cpu_pc;
    logic             cpu_rst_n;
    logic             busy;
    logic             done;
    logic             timeout;
    logic             stall;
    logic [PC_W-1:0]  halt_pc;
    logic [CNT_W-1:0] cycle_count;
`ifdef RUN_CTRL_TRACE_EN
    logic [2:0]       trace_idx;
    logic [PC_W-1:0]  trace_pc;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    cpu_run_ctrl #(
        .PC_W       (PC_W),
        .CNT_W      (CNT_W),
        .RST_CYCLES (RST_CYCLES),
        .MAX_CYCLES (MAX_CYCLES),
        .STALL_LIMIT(STALL_LIMIT),
        .TRACE_DEPTH(TRACE_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cpu_hlt    (cpu_hlt),
        .cpu_pc     (cpu_pc),
        .cpu_rst_n  (cpu_rst_n),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .stall      (stall),
        .halt_pc    (halt_pc),
        .cycle_count(cycle_count)
`ifdef RUN_CTRL_TRACE_EN
        ,
        .trace_idx  (trace_idx),
        .trace_pc   (trace_pc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic pcq_t build_pcs(input int stuck_from, input int stuck_pc);
        pcq_t q;
        for (int i = 0; i < MAX_CYCLES; i++) begin
            q.push_back((i >= stuck_from) ? stuck_pc : i);
        end
        return q;
    endfunction

    // Run-level model: walk the planned PC trace and find the terminating cycle
    function automatic void model_run(input pcq_t pcs, input int halt_at, output int k,
                                      output bit to, output bit st, output int hpc);
        int same_len;
        same_len = 0;
        k = MAX_CYCLES - 1; to = 1'b1; st = 1'b0; hpc = int'(pcs[MAX_CYCLES-1]);
        for (int i = 0; i < MAX_CYCLES; i++) begin
            same_len = (i > 0 && pcs[i] == pcs[i-1]) ? same_len + 1 : 1;
            if (i == halt_at) begin
                k = i; to = 1'b0; st = 1'b0; hpc = int'(pcs[i]); break;
            end else if (i == MAX_CYCLES - 1) begin
                k = i; to = 1'b1; st = 1'b0; hpc = int'(pcs[i]); break;
            end else if (same_len >= STALL_LIMIT) begin
                k = i; to = 1'b0; st = 1'b1; hpc = int'(pcs[i]); break;
            end
        end
    endfunction

    task automatic run_and_check(input string tag, input pcq_t pcs, input int halt_at,
                                 input bit start_in_run, input int exp_k, input bit exp_to,
                                 input bit exp_st, input int exp_hpc);
        int n_rst, n_run, guard;
        n_rst = 0; n_run = 0; guard = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({tag, "/clear_flags"}, {timeout, stall, done}, 0);
        chk({tag, "/clear_halt_pc"}, halt_pc, 0);
        chk({tag, "/clear_count"}, cycle_count, 0);
        while (!cpu_rst_n && guard < 64) begin
            if (busy) n_rst++;
            guard++;
            @(negedge clk);
        end
        chk({tag, "/reset_len"}, n_rst, RST_CYCLES);
        while (busy && cpu_rst_n && n_run < 64) begin
            chk({tag, "/run_count"}, cycle_count, n_run);
            cpu_pc  = PC_W'((n_run < pcs.size()) ? pcs[n_run] : 0);
            cpu_hlt = (n_run == halt_at);
            start   = start_in_run && (n_run == 3);
            @(negedge clk);
            n_run++;
        end
        cpu_hlt = 1'b0;
        start   = 1'b0;
        chk({tag, "/run_len"}, n_run, exp_k + 1);
        chk({tag, "/done"}, {done, busy, cpu_rst_n}, 3'b101);
        chk({tag, "/timeout"}, timeout, exp_to);
        chk({tag, "/stall"}, stall, exp_st);
        chk({tag, "/halt_pc"}, halt_pc, exp_hpc);
        chk({tag, "/cycle_count"}, cycle_count, exp_k);
`ifdef RUN_CTRL_TRACE_EN
        for (int i = 0; i < TRACE_DEPTH; i++) begin
            trace_idx = 3'(i);
            #1;
            chk({tag, "/trace"}, trace_pc, (exp_k >= i) ? int'(pcs[exp_k - i]) : 0);
        end
`endif
        // cpu inputs are ignored once DONE
        cpu_hlt = 1'b1;
        cpu_pc  = 8'hA5;
        @(negedge clk);
        cpu_hlt = 1'b0;
        chk({tag, "/done_hold"}, {done, halt_pc}, {1'b1, PC_W'(exp_hpc)});
        chk({tag, "/done_count_hold"}, cycle_count, exp_k);
    endtask

    vec_t vecs[11];

    initial begin
        int guard;
        vecs[0]  = '{"basic",         NONE, 0,   5,    1'b0, 5,  1'b0, 1'b0, 5};
        vecs[1]  = '{"watchdog",      NONE, 0,   NONE, 1'b1, 19, 1'b1, 1'b0, 19};
        vecs[2]  = '{"restart",       NONE, 0,   5,    1'b0, 5,  1'b0, 1'b0, 5};
        vecs[3]  = '{"stall",         2,    7,   NONE, 1'b0, 5,  1'b0, 1'b1, 7};
        vecs[4]  = '{"stall_vs_halt", 2,    7,   5,    1'b0, 5,  1'b0, 1'b0, 7};
        vecs[5]  = '{"stuck_at_0",    0,    0,   NONE, 1'b0, 3,  1'b0, 1'b1, 0};
        vecs[6]  = '{"halt_first",    NONE, 0,   0,    1'b0, 0,  1'b0, 1'b0, 0};
        vecs[7]  = '{"halt_vs_wdog",  NONE, 0,   19,   1'b0, 19, 1'b0, 1'b0, 19};
        vecs[8]  = '{"wdog_vs_stall", 16,   200, NONE, 1'b0, 19, 1'b1, 1'b0, 200};
        vecs[9]  = '{"halt_11",       NONE, 0,   11,   1'b0, 11, 1'b0, 1'b0, 11};
        vecs[10] = '{"halt_2",        NONE, 0,   2,    1'b0, 2,  1'b0, 1'b0, 2};

        rst = 1'b1; start = 1'b0; cpu_hlt = 1'b0; cpu_pc = '0;
`ifdef RUN_CTRL_TRACE_EN
        trace_idx = '0;
`endif
        repeat (2) @(negedge clk);
        chk("reset/status", {cpu_rst_n, busy, done, timeout, stall}, 0);
        chk("reset/halt_pc", halt_pc, 0);
        chk("reset/cycle_count", cycle_count, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle/no_start", {busy, cpu_rst_n}, 0);

        // reset while in RESET
        start = 1'b1; @(negedge clk); start = 1'b0;
        chk("mid_reset/busy", busy, 1);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        chk("mid_reset/idle", {busy, cpu_rst_n, done}, 0);
        @(negedge clk);
        chk("mid_reset/stay_idle", busy, 0);

        // reset in RUN cycle 10, with start held during reset
        start = 1'b1; @(negedge clk); start = 1'b0;
        guard = 0;
        while (!cpu_rst_n && guard < 64) begin guard++; @(negedge clk); end
        chk("mid_run/reached_run", cpu_rst_n, 1);
        for (int k = 0; k < 10; k++) begin
            cpu_pc = PC_W'(k);
            @(negedge clk);
        end
        chk("mid_run/count10", cycle_count, 10);
        chk("mid_run/busy", {busy, cpu_rst_n}, 2'b11);
        cpu_pc = 8'd10; rst = 1'b1;
        @(negedge clk);
        chk("mid_run/status", {cpu_rst_n, busy, done, timeout, stall}, 0);
        chk("mid_run/halt_pc", halt_pc, 0);
        chk("mid_run/cycle_count", cycle_count, 0);
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("start_in_rst/ignored", {busy, cpu_rst_n}, 0);

        foreach (vecs[i]) begin
            run_and_check(vecs[i].name, build_pcs(vecs[i].stuck_from, vecs[i].stuck_pc),
                          vecs[i].halt_at, vecs[i].start_in_run, vecs[i].exp_cc,
                          vecs[i].exp_to, vecs[i].exp_st, vecs[i].exp_hpc);
        end

        for (int r = 0; r < 24; r++) begin : rnd
            pcq_t pcs;
            int   halt_at, k, hpc;
            bit   to, st;
            pcs = {};
            for (int i = 0; i < MAX_CYCLES; i++) begin
                if (i > 0 && $urandom_range(0, 9) < 4) pcs.push_back(pcs[i-1]);
                else pcs.push_back($urandom_range(0, 255));
            end
            halt_at = int'($urandom_range(0, 30));
            model_run(pcs, halt_at, k, to, st, hpc);
            run_and_check("random", pcs, halt_at, r[0], k, to, st, hpc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, %0d/%0d checks passed",
                 n_pass, n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cpu_run_ctrl.md
CPU_RUN_CTRL -- requirements
Module: cpu_run_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 8: width of the CPU program counter.
REQ-002 SHALL have parameter CNT_W, default 16: cycle-counter width.
REQ-003 SHALL have parameter RST_CYCLES, default 3: number of cycles the CPU is held in reset, range 1..255.
REQ-004 SHALL have parameter MAX_CYCLES, default 1000: watchdog limit, range 1..2^CNT_W-1.
REQ-005 SHALL have parameter STALL_LIMIT, default 16: number of consecutive RUN cycles with an unchanged PC that counts as a stall, range 2..255.
REQ-006 SHALL have parameter TRACE_DEPTH, default 8: PC history entries, a power of 2.
REQ-007 SHALL have one clock, clk; reset is rst, synchronous and active-high.
REQ-008 Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  run request, single-cycle level
- cpu_hlt  in  1  CPU halt flag
- cpu_pc  in  PC_W  CPU program counter
- cpu_rst_n  out  1  active-low reset driven to the CPU, registered
- busy  out  1  high in RESET or RUN
- done  out  1  high in DONE
- timeout  out  1  sticky: watchdog expired
- stall  out  1  sticky: PC stalled
- halt_pc  out  PC_W  PC captured at termination
- cycle_count  out  CNT_W  number of RUN cycles elapsed
- trace_idx  in  log2(TRACE_DEPTH)  history read index (present only with the macro)
- trace_pc  out  PC_W  history read data (present only with the macro)

Function
REQ-009 FSM SHALL have the states IDLE, RESET, RUN and DONE.
REQ-010 Transitions:
- IDLE & start -> RESET.
- RESET stays for exactly RST_CYCLES cycles -> RUN.
- RUN terminates -> DONE.
- DONE & start -> RESET.
- start SHALL be ignored in RESET and RUN.
REQ-011 cpu_rst_n SHALL be 0 in IDLE and RESET and 1 in RUN and DONE, driven from a register aligned with the state.
REQ-012 On entering RESET: timeout, stall, halt_pc and cycle_count SHALL clear to 0 and the stall counter SHALL clear.
REQ-013 cycle_count SHALL be 0 in the first RUN cycle, increment by 1 on each RUN edge that does not terminate, and hold in DONE.
REQ-014 Halt: cpu_hlt sampled high in RUN SHALL move the FSM to DONE, capture cpu_pc of that cycle into halt_pc, and freeze cycle_count at its current value.
REQ-015 Watchdog: in RUN, cycle_count == MAX_CYCLES-1 with cpu_hlt low SHALL move the FSM to DONE with timeout=1, halt_pc = that cycle's cpu_pc, and cycle_count held at MAX_CYCLES-1.
REQ-016 Stall counting SHALL work as follows:
- The previous PC is registered on every RUN cycle.
- The stall counter resets to 0 when cpu_pc differs from the previous PC, or in the first RUN cycle.
- Otherwise it increments.
REQ-017 A stall counter reaching STALL_LIMIT-1 with an unchanged PC SHALL move the FSM to DONE with stall=1 and halt_pc captured.
REQ-018 Simultaneous termination priority SHALL be halt > timeout > stall; only the winning flag is set.
REQ-019 cpu_hlt and cpu_pc SHALL be ignored outside RUN.
REQ-020 done, busy, timeout and stall SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-021 rst high on any edge, including mid-RESET or mid-RUN, SHALL force IDLE.
REQ-022 rst SHALL drive these outputs to 0 on the next edge: cpu_rst_n, busy, done, timeout, stall, halt_pc, cycle_count and all internal counters.
REQ-023 start asserted during rst SHALL be ignored.

Configuration
REQ-024 Macro RUN_CTRL_TRACE_EN defined: a TRACE_DEPTH-entry circular PC history SHALL be instantiated.
- It is written with cpu_pc on every RUN cycle, including the terminating cycle.
- Its write pointer clears on entry to RESET.
- trace_pc = entry (wptr-1-trace_idx) mod TRACE_DEPTH, combinational from the registered array; index 0 is the most recent PC.
- Entries never written since RESET read 0.
REQ-025 Macro RUN_CTRL_TRACE_EN undefined: trace_idx, trace_pc and all history storage SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-026 Basic run: rst 2 cycles, start pulse; CPU PC increments 0..5, cpu_hlt rises at PC=5 -> cpu_rst_n low exactly 3 cycles; done=1, halt_pc=5, cycle_count=5, timeout=0, stall=0.
REQ-027 Watchdog: MAX_CYCLES=20, PC keeps incrementing, cpu_hlt never rises -> DONE after 20 RUN cycles, timeout=1, cycle_count=19.
REQ-028 Stall: STALL_LIMIT=4, PC stuck at 7 from RUN cycle 2 -> stall=1 at the edge of RUN cycle 5, halt_pc=7; cpu_hlt raised in that same cycle -> stall=0, done=1.
REQ-029 Reset mid-run: rst asserted in RUN cycle 10 -> next edge IDLE, cpu_rst_n=0, all outputs 0; a subsequent start reruns with cycle_count starting at 0.
REQ-030 Restart and ignore: start pulsed in RUN -> no effect; start in DONE after a timeout -> flags cleared, RESET re-entered, new run completes normally.
REQ-031 Trace (macro defined, depth 8): halt at PC=11 after PCs 0..11 -> trace_pc at idx 0..7 reads 11 down to 4; halt at PC=2 -> idx 3 reads 0.
